// File: rtl/vpu_pkg.sv
// Shared types, constants and the saturating clamp used by the VPU datapath lanes.
package vpu_pkg;
  localparam int DATA_W     = 16;
  localparam int FRAC_W     = 8;
  localparam int MODE_BIAS  = 0;
  localparam int MODE_LRELU = 1;

  typedef logic signed [DATA_W-1:0] data_t;

  localparam data_t LEAK_DEFAULT = 16'sh001A;
  localparam logic signed [32:0] ROUND_HALF = 33'sd1 <<< (FRAC_W - 1);

  // Clamp a wide signed intermediate into the 16-bit element range.
  function automatic data_t sat16(input logic signed [32:0] v);
    if (v > 33'sd32767) begin
      return 16'sh7FFF;
    end else if (v < -33'sd32768) begin
      return 16'sh8000;
    end else begin
      return v[15:0];
    end
  endfunction
endpackage

// File: rtl/vpu_lane.sv
// One lane of the datapath: input register, saturating bias stage, leaky-ReLU stage.
module vpu_lane
  import vpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  data_t      leak,
  input  data_t      data_in,
  input  data_t      bias_in,
  input  logic       valid_in,
  output data_t      data_out,
  output logic       valid_out
);
  logic       valid1_r, valid2_r;
  data_t      x1_r, bias1_r, leak1_r, x2_r, leak2_r;
  logic [1:0] mode1_r, mode2_r;

  logic signed [32:0] bias_sum_s, prod_s, scaled_s;
  data_t              s2_next_s, act_s;

  // S1: capture operands and the per-element mode; data holds across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid1_r <= 1'b0;
      x1_r     <= 16'sh0000;
      bias1_r  <= 16'sh0000;
      leak1_r  <= 16'sh0000;
      mode1_r  <= 2'b00;
    end else begin
      valid1_r <= valid_in;
      if (valid_in) begin
        x1_r    <= data_in;
        bias1_r <= bias_in;
        leak1_r <= leak;
        mode1_r <= mode;
      end
    end
  end

  // Saturating bias add or operand pass-through.
  always_comb begin
    bias_sum_s = 33'(x1_r) + 33'(bias1_r);
    if (mode1_r[MODE_BIAS]) begin
      s2_next_s = sat16(bias_sum_s);
    end else begin
      s2_next_s = x1_r;
    end
  end

  // S2 register: biased value plus forwarded leak and mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid2_r <= 1'b0;
      x2_r     <= 16'sh0000;
      leak2_r  <= 16'sh0000;
      mode2_r  <= 2'b00;
    end else begin
      valid2_r <= valid1_r;
      if (valid1_r) begin
        x2_r    <= s2_next_s;
        leak2_r <= leak1_r;
        mode2_r <= mode1_r;
      end
    end
  end

  // Leaky ReLU on negatives: round-half-up rescale of x*leak, then clamp.
  always_comb begin
    prod_s   = 33'(x2_r) * 33'(leak2_r);
    scaled_s = (prod_s + ROUND_HALF) >>> FRAC_W;
    if (mode2_r[MODE_LRELU] && x2_r[DATA_W-1]) begin
      act_s = sat16(scaled_s);
    end else begin
      act_s = x2_r;
    end
  end

  // Output register: the last valid result stays on the port during bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      data_out  <= 16'sh0000;
    end else begin
      valid_out <= valid2_r;
      if (valid2_r) begin
        data_out <= act_s;
      end
    end
  end
endmodule

// File: rtl/vpu_datapath.sv
// Four independent lanes sharing the pathway mode and leak factor from the VPU controller.
module vpu_datapath
  import vpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] vpu_data_pathway,
  input  data_t      vpu_data_in_1,
  input  data_t      vpu_data_in_2,
  input  data_t      vpu_data_in_3,
  input  data_t      vpu_data_in_4,
  input  logic       vpu_valid_in_1,
  input  logic       vpu_valid_in_2,
  input  logic       vpu_valid_in_3,
  input  logic       vpu_valid_in_4,
  input  data_t      bias_scalar_in_1,
  input  data_t      bias_scalar_in_2,
  input  data_t      bias_scalar_in_3,
  input  data_t      bias_scalar_in_4,
  input  data_t      lr_leak_factor_in,
  output data_t      vpu_data_out_1,
  output data_t      vpu_data_out_2,
  output data_t      vpu_data_out_3,
  output data_t      vpu_data_out_4,
  output logic       vpu_valid_out_1,
  output logic       vpu_valid_out_2,
  output logic       vpu_valid_out_3,
  output logic       vpu_valid_out_4
);
  logic [1:0] mode_s;
  logic       unused_pathway_s;

  assign mode_s           = vpu_data_pathway[1:0];
  assign unused_pathway_s = ^vpu_data_pathway[3:2];

  vpu_lane u_lane1 (
    .clk(clk), .rst_n(rst_n), .mode(mode_s), .leak(lr_leak_factor_in),
    .data_in(vpu_data_in_1), .bias_in(bias_scalar_in_1), .valid_in(vpu_valid_in_1),
    .data_out(vpu_data_out_1), .valid_out(vpu_valid_out_1)
  );

  vpu_lane u_lane2 (
    .clk(clk), .rst_n(rst_n), .mode(mode_s), .leak(lr_leak_factor_in),
    .data_in(vpu_data_in_2), .bias_in(bias_scalar_in_2), .valid_in(vpu_valid_in_2),
    .data_out(vpu_data_out_2), .valid_out(vpu_valid_out_2)
  );

  vpu_lane u_lane3 (
    .clk(clk), .rst_n(rst_n), .mode(mode_s), .leak(lr_leak_factor_in),
    .data_in(vpu_data_in_3), .bias_in(bias_scalar_in_3), .valid_in(vpu_valid_in_3),
    .data_out(vpu_data_out_3), .valid_out(vpu_valid_out_3)
  );

  vpu_lane u_lane4 (
    .clk(clk), .rst_n(rst_n), .mode(mode_s), .leak(lr_leak_factor_in),
    .data_in(vpu_data_in_4), .bias_in(bias_scalar_in_4), .valid_in(vpu_valid_in_4),
    .data_out(vpu_data_out_4), .valid_out(vpu_valid_out_4)
  );
endmodule

// File: tb/tb_vpu_datapath.sv
// Directed bench for vpu_datapath: latency, bias/leaky-ReLU arithmetic, saturation, streaming, reset.
module tb_vpu_datapath;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  pathway;
  logic [15:0] din  [4];
  logic [15:0] bias [4];
  logic [3:0]  vin;
  logic [15:0] leak;
  logic [15:0] dout [4];
  logic [3:0]  vout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vpu_datapath dut (
    .clk(clk), .rst_n(rst_n), .vpu_data_pathway(pathway),
    .vpu_data_in_1(din[0]), .vpu_data_in_2(din[1]), .vpu_data_in_3(din[2]), .vpu_data_in_4(din[3]),
    .vpu_valid_in_1(vin[0]), .vpu_valid_in_2(vin[1]), .vpu_valid_in_3(vin[2]), .vpu_valid_in_4(vin[3]),
    .bias_scalar_in_1(bias[0]), .bias_scalar_in_2(bias[1]), .bias_scalar_in_3(bias[2]), .bias_scalar_in_4(bias[3]),
    .lr_leak_factor_in(leak),
    .vpu_data_out_1(dout[0]), .vpu_data_out_2(dout[1]), .vpu_data_out_3(dout[2]), .vpu_data_out_4(dout[3]),
    .vpu_valid_out_1(vout[0]), .vpu_valid_out_2(vout[1]), .vpu_valid_out_3(vout[2]), .vpu_valid_out_4(vout[3])
  );

  task automatic test_reset();
    rst_n = 1'b1; pathway = 4'b0000; vin = 4'b0000; leak = 16'h001A;
    for (int l = 0; l < 4; l++) begin din[l] = 16'h0000; bias[l] = 16'h0000; end
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int l = 0; l < 4; l++) begin
      total++;
      if (vout[l] !== 1'b0) begin bad++; $display("FAIL reset_valid lane%0d: got %b want 0", l, vout[l]); end
      total++;
      if (dout[l] !== 16'h0000) begin bad++; $display("FAIL reset_data lane%0d: got %h want 0000", l, dout[l]); end
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_bias_latency();
    pathway = 4'b0001; din[0] = 16'h0100; bias[0] = 16'h0080; vin = 4'b0001;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) vin = 4'b0000;
      total++;
      if (vout[0] !== (c == 3)) begin bad++; $display("FAIL latency_valid cycle%0d: got %b want %b", c, vout[0], (c == 3)); end
      if (c >= 3) begin
        total++;
        if (dout[0] !== 16'h0180) begin bad++; $display("FAIL bias_add cycle%0d: got %h want 0180", c, dout[0]); end
      end
      total++;
      if (vout[3:1] !== 3'b000) begin bad++; $display("FAIL other_lanes cycle%0d: got %b want 000", c, vout[3:1]); end
    end
  endtask

  task automatic test_lrelu();
    logic [15:0] exp_d [4];
    pathway = 4'b0011; leak = 16'h001A;
    din[0] = 16'hFF00; din[1] = 16'h0200; din[2] = 16'h8000; din[3] = 16'hFFFF;
    for (int l = 0; l < 4; l++) bias[l] = 16'h0000;
    exp_d[0] = 16'hFFE6; exp_d[1] = 16'h0200; exp_d[2] = 16'hF300; exp_d[3] = 16'h0000;
    vin = 4'b1111;
    @(negedge clk); vin = 4'b0000;
    repeat (2) @(negedge clk);
    for (int l = 0; l < 4; l++) begin
      total++;
      if (vout[l] !== 1'b1 || dout[l] !== exp_d[l]) begin
        bad++; $display("FAIL lrelu lane%0d: got v=%b %h want v=1 %h", l, vout[l], dout[l], exp_d[l]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    logic [15:0] exp_d [4];
    pathway = 4'b0011; leak = 16'h001A;
    din[0] = 16'h7F00; bias[0] = 16'h0200; exp_d[0] = 16'h7FFF;
    din[1] = 16'h8100; bias[1] = 16'hFE00; exp_d[1] = 16'hF300;
    din[2] = 16'h4000; bias[2] = 16'h4000; exp_d[2] = 16'h7FFF;
    din[3] = 16'hFF00; bias[3] = 16'h0100; exp_d[3] = 16'h0000;
    vin = 4'b1111;
    @(negedge clk); vin = 4'b0000;
    repeat (2) @(negedge clk);
    for (int l = 0; l < 4; l++) begin
      total++;
      if (vout[l] !== 1'b1 || dout[l] !== exp_d[l]) begin
        bad++; $display("FAIL saturation lane%0d: got v=%b %h want v=1 %h", l, vout[l], dout[l], exp_d[l]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reserved_bits();
    pathway = 4'b1101; leak = 16'h001A;
    din[2] = 16'hFF00; bias[2] = 16'h0080; vin = 4'b0100;
    @(negedge clk); vin = 4'b0000;
    repeat (2) @(negedge clk);
    total++;
    if (vout[2] !== 1'b1 || dout[2] !== 16'hFF80) begin
      bad++; $display("FAIL reserved_bits: got v=%b %h want v=1 ff80", vout[2], dout[2]);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic        exp_v [13];
    logic [15:0] exp_d [13][4];
    logic [15:0] hold_d [4];
    int          e;
    for (int s = 0; s < 13; s++) exp_v[s] = 1'b0;
    leak = 16'h001A;
    for (int s = 0; s < 13; s++) begin
      if (s >= 3) begin
        for (int l = 0; l < 4; l++) begin
          total++;
          if (vout[l] !== exp_v[s-3]) begin
            bad++; $display("FAIL stream_valid slot%0d lane%0d: got %b want %b", s, l, vout[l], exp_v[s-3]);
          end
          if (exp_v[s-3]) begin
            total++;
            if (dout[l] !== exp_d[s-3][l]) begin
              bad++; $display("FAIL stream_data slot%0d lane%0d: got %h want %h", s, l, dout[l], exp_d[s-3][l]);
            end
            hold_d[l] = exp_d[s-3][l];
          end else if (s >= 4) begin
            total++;
            if (dout[l] !== hold_d[l]) begin
              bad++; $display("FAIL stream_hold slot%0d lane%0d: got %h want %h", s, l, dout[l], hold_d[l]);
            end
          end
        end
      end
      if (s < 9 && s != 4) begin
        e = (s < 4) ? s : s - 1;
        pathway = (e < 5) ? 4'b0001 : 4'b0000;
        for (int l = 0; l < 4; l++) begin
          din[l]  = 16'((e + 1) * 256 + l * 16);
          bias[l] = 16'(16 * (l + 1));
          exp_d[s][l] = (e < 5) ? 16'(din[l] + bias[l]) : din[l];
        end
        exp_v[s] = 1'b1;
        vin = 4'b1111;
      end else begin
        vin = 4'b0000;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midstream();
    pathway = 4'b0001;
    for (int l = 0; l < 4; l++) begin din[l] = 16'h0300; bias[l] = 16'h0001; end
    vin = 4'b1111;
    @(negedge clk);
    for (int l = 0; l < 4; l++) din[l] = 16'h0400;
    @(negedge clk);
    vin = 4'b0000;
    #2 rst_n = 1'b0;
    #1;
    for (int l = 0; l < 4; l++) begin
      total++;
      if (vout[l] !== 1'b0 || dout[l] !== 16'h0000) begin
        bad++; $display("FAIL midreset_clear lane%0d: got v=%b %h want v=0 0000", l, vout[l], dout[l]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (vout !== 4'b0000) begin bad++; $display("FAIL midreset_novalid cycle%0d: got %b want 0000", c, vout); end
    end
    pathway = 4'b0000; din[1] = 16'h1234; vin = 4'b0010;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) vin = 4'b0000;
      total++;
      if (vout !== ((c == 3) ? 4'b0010 : 4'b0000)) begin
        bad++; $display("FAIL postreset_valid cycle%0d: got %b", c, vout);
      end
    end
    total++;
    if (dout[1] !== 16'h1234) begin bad++; $display("FAIL postreset_data: got %h want 1234", dout[1]); end
  endtask

  initial begin
    test_reset();
    test_bias_latency();
    test_lrelu();
    test_saturation();
    test_reserved_bits();
    test_back_to_back();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vpu_datapath.md
Name: vpu_datapath

Overview:
4-lane pipelined vector processing datapath that sits directly downstream of the VPU controller. It consumes the controller's per-lane Z' elements, per-lane bias scalars and leak factor, and applies bias-add and/or leaky ReLU in Q8.8 fixed point. It returns per-lane results with valid flags for capture into the controller's output buffer.
- Fixed 3-cycle latency and full throughput: one element per lane per cycle, no backpressure.

Parameters:
DATA_W, 16, element width (signed two's complement)
FRAC_W, 8, fractional bits of the fixed-point format (Q8.8)
LANES, 4, number of parallel lanes (ports are written out for 4; other values unsupported)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
vpu_data_pathway  in  4  mode: [0] bias add, [1] leaky ReLU, [3:2] reserved, ignored
vpu_data_in_1..4  in  DATA_W each  signed lane operands (Z')
vpu_valid_in_1..4  in  1 each  per-lane input valid
bias_scalar_in_1..4  in  DATA_W each  signed per-lane bias
lr_leak_factor_in  in  DATA_W  signed leak slope, Q8.8
vpu_data_out_1..4  out  DATA_W each  signed lane results
vpu_valid_out_1..4  out  1 each  per-lane output valid

Behaviour:
- Reset (rst_n=0, asynchronous): all pipeline data registers, mode registers and valid registers clear to 0. All vpu_data_out_* = 0 and all vpu_valid_out_* = 0 immediately. In-flight data is discarded with no partial outputs after release. Normal operation starts on the first rising edge after rst_n deasserts.
- Lanes are independent. Each lane carries its own valid and a copy of mode bits [1:0] through every stage. Mode is therefore sampled per element at S1, and a pathway change mid-stream affects only elements entering after the change.
- S1 (input register): when valid_in=1, capture operand, bias, leak and mode[1:0].
  - When valid_in=0, set valid to 0 and hold the data registers (no toggling).
- S2 (bias stage):
  - If mode[0]=1: compute a 17-bit sum of operand and bias, saturated to [-32768, 32767].
  - If mode[0]=0: pass the operand through.
  - Leak and mode are forwarded.
- S3 (activation stage):
  - If mode[1]=1 and x<0: form the 32-bit product x*leak, add 2^(FRAC_W-1) (=128), arithmetic shift right by FRAC_W, then saturate to 16 bits.
  - If mode[1]=1 and x>=0: output x.
  - If mode[1]=0: output x.
- Output register: vpu_data_out_n and vpu_valid_out_n are registered.
  - valid_out follows valid_in by exactly 3 clock edges.
  - Data is held when valid is 0, so the last valid result stays on the port.
- mode[1:0]=00 is a pure 3-cycle delay line.
- Back-to-back valids produce back-to-back outputs. Bubbles (valid_in=0) are preserved position-exactly.
- All arithmetic is signed. There is no wrap-around anywhere: every add and every rescaled product saturates.
- Reserved pathway bits have no effect.

Decomposition:
- Package vpu_pkg:
  - constants DATA_W=16, FRAC_W=8
  - mode bit indices MODE_BIAS=0, MODE_LRELU=1
  - typedef data_t (signed DATA_W), function sat16 (signed 33-bit to data_t clamp)
  - constant LEAK_DEFAULT=16'sh001A
- Sub-module vpu_lane: one lane's 3-stage pipeline (valid, data, mode, leak). It is instantiated 4x by vpu_datapath, which only fans out the shared leak and mode signals.

Test Plan:
- Reset, then pathway=0001, lane1 in=0x0100, bias=0x0080, valid one cycle -> vpu_valid_out_1 high exactly 3 cycles later with 0x0180; the other lanes stay invalid.
- Pathway=0011, in=0xFF00 (-1.0), bias=0, leak=0x001A -> out 0xFFE6 (-6528>>>8 = -26). Same setup with in=0x0200 -> out 0x0200.
- Saturation, pathway=0011, leak=0x001A: in=0x7F00, bias=0x0200 -> 0x7FFF. In=0x8100, bias=0xFE00 -> bias sum saturates to 0x8000, leaky result 0xF300.
- Streaming: 8 consecutive valids on all 4 lanes, with a 1-cycle bubble after the 4th and pathway switched 0001->0000 at the 6th -> 8 outputs in order with the bubble preserved; elements 6-8 equal their raw inputs.
- Reset mid-stream: assert rst_n=0 while 2 elements are in flight -> outputs and valids are 0 immediately; no valid appears after release until new inputs arrive plus 3 cycles.
